// File: rtl/in_port_pkg.sv
// in_port_pkg
// Shared definitions for the input-port receiver:
//   - hs_state_t   : handshake FSM state encoding (IDLE, ACK)
//   - SYNC_STAGES  : depth of the ext_req synchronizer
//   - cnt_width()  : width of an occupancy counter that must hold 0..DEPTH
package in_port_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs_state_t;

  localparam int SYNC_STAGES = 2;

  // A counter for 0..DEPTH needs one bit more than a pointer into DEPTH slots.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/in_port_rx_sync2.sv
// sync2
// Two-flop synchronizer for a single asynchronous level signal.
// Both flops clear on reset so a stale request never survives a reset.
// Ports:
//   clk   in  sampling clock
//   reset in  asynchronous, active-high reset
//   d     in  asynchronous input level
//   q     out synchronized level, SYNC_STAGES clocks behind d
module sync2
  import in_port_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift the input through the chain; only the last stage is used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/in_port_rx.sv
// in_port_rx
// Input-port receiver: takes bytes from an external producer over a 4-phase
// req/ack handshake and buffers them in a small show-ahead FIFO that the CPU
// drains with a one-cycle read strobe.
//
// Build option: define IN_PORT_SYNC_EN to pass ext_req through a 2-flop
// synchronizer (needed when the producer is asynchronous to clk). Without it,
// ext_req is used directly and must be synchronous to clk.
//
// Parameters:
//   WIDTH  data width in bits
//   DEPTH  FIFO entries (power of two, >= 2)
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   reset     in   asynchronous, active-high reset
//   ext_req   in   producer request
//   ext_data  in   producer data, stable while ext_req is high
//   ext_ack   out  registered handshake acknowledge
//   rd        in   CPU pop strobe
//   rd_data   out  FIFO head, 0 when empty
//   rd_valid  out  FIFO not empty
//   full      out  FIFO holds DEPTH entries
//   count     out  number of stored entries
module in_port_rx
  import in_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ext_req,
  input  logic [WIDTH-1:0]              ext_data,
  output logic                          ext_ack,
  input  logic                          rd,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          rd_valid,
  output logic                          full,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic              req_s;
  hs_state_t         state_q;
  hs_state_t         state_d;
  logic              wr_en;
  logic              rd_en;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [WIDTH-1:0]  mem [0:DEPTH-1];

  // Request input stage: synchronized or taken as-is depending on the build.
`ifdef IN_PORT_SYNC_EN
  sync2 u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (ext_req),
    .q     (req_s)
  );
`else
  assign req_s = ext_req;
`endif

  // Handshake state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A byte is written only on the IDLE->ACK transition, so
  // each request high phase produces exactly one write. A full FIFO keeps the
  // FSM in IDLE and the producer simply waits with ack low.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && !full) begin
          wr_en   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ack comes straight from the state flop, so it is glitch-free toward the producer.
  assign ext_ack = (state_q == ACK);

  // Pops on an empty FIFO are dropped here so pointers and count never move.
  assign rd_en = rd && rd_valid;

  // Storage needs no reset: empty slots are never visible because rd_data
  // is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= ext_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Occupancy: a simultaneous write and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full     = (count == DEPTH_C);
  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_in_port_rx.sv
// tb_in_port_rx
// Self-checking bench for in_port_rx (WIDTH=8, DEPTH=4). Works with or
// without IN_PORT_SYNC_EN; request latency is taken from the same macro.
// The reference model is a plain byte queue updated from producer-visible
// events: a rising ext_ack means the driven byte was accepted, and a rd
// strobe with a non-empty queue removes the head.
module tb_in_port_rx;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef IN_PORT_SYNC_EN
  localparam int REQ_LAT = 2;
`else
  localparam int REQ_LAT = 0;
`endif
  localparam int PERIOD = 2 + 2 * REQ_LAT;

  logic             clk;
  logic             reset;
  logic             ext_req;
  logic [WIDTH-1:0] ext_data;
  logic             ext_ack;
  logic             rd;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic [2:0]       count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] model[$];
  logic [WIDTH-1:0] sent[$];
  logic [WIDTH-1:0] popped[$];
  logic             ack_prev = 1'b0;

  in_port_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .ext_req  (ext_req),
    .ext_data (ext_data),
    .ext_ack  (ext_ack),
    .rd       (rd),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .count    (count)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some loop never terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, advance the model at the rising
  // edge, then compare every output against the model.
  task automatic applyStimulus(input logic req_v, input logic [WIDTH-1:0] data_v, input logic rd_v);
    int pre_size;
    logic [WIDTH-1:0] pre_head;
    logic pre_valid;
    @(negedge clk);
    ext_req  = req_v;
    ext_data = data_v;
    rd       = rd_v;
    pre_head  = rd_data;
    pre_valid = rd_valid;
    @(posedge clk);
    pre_size = model.size();
    #1;
    if (rd_v && pre_valid) popped.push_back(pre_head);
    if (rd_v && pre_size > 0) void'(model.pop_front());
    if (ext_ack && !ack_prev) begin
      checkOutput("write_not_when_full", (pre_size < DEPTH), 1);
      model.push_back(data_v);
    end
    ack_prev = ext_ack;
    checkOutput("count", count, model.size());
    checkOutput("rd_valid", rd_valid, (model.size() != 0));
    checkOutput("full", full, (model.size() == DEPTH));
    checkOutput("rd_data", rd_data, (model.size() != 0) ? model[0] : 8'h00);
  endtask

  task automatic sendByte(input logic [WIDTH-1:0] d);
    for (int i = 0; i < 20 && !ext_ack; i++) applyStimulus(1'b1, d, 1'b0);
    checkOutput("send_ack_high", ext_ack, 1);
    for (int i = 0; i < 20 && ext_ack; i++) applyStimulus(1'b0, d, 1'b0);
    checkOutput("send_ack_low", ext_ack, 0);
  endtask

  task automatic popByte(input logic [WIDTH-1:0] exp);
    checkOutput("pop_head", rd_data, exp);
    applyStimulus(1'b0, 8'h00, 1'b1);
  endtask

  // Producer runs at full speed for n random bytes; rd is always high or
  // random. Afterwards the FIFO is drained and the DUT's pop sequence is
  // compared against what was sent.
  task automatic streamBytes(input int n, input logic rd_random, input int max_cycles, output int cycles);
    logic req_now = 1'b0;
    logic [WIDTH-1:0] cur = '0;
    int n_sent = 0;
    cycles = 0;
    sent.delete();
    popped.delete();
    while ((n_sent < n || req_now || ext_ack) && cycles < max_cycles) begin
      if (!req_now && !ext_ack && n_sent < n) begin
        req_now = 1'b1;
        cur = WIDTH'($urandom);
        sent.push_back(cur);
        n_sent++;
      end else if (req_now && ext_ack) begin
        req_now = 1'b0;
      end
      applyStimulus(req_now, cur, rd_random ? ($urandom_range(0, 2) == 0) : 1'b1);
      cycles++;
    end
    for (int i = 0; i < 40 && model.size() != 0; i++) applyStimulus(1'b0, cur, 1'b1);
    checkOutput("stream_received", popped.size(), n);
    for (int i = 0; i < n && i < popped.size(); i++) begin
      checkOutput("stream_order", popped[i], sent[i]);
    end
  endtask

  initial begin
    int cycles;
    reset    = 1'b1;
    ext_req  = 1'b0;
    ext_data = '0;
    rd       = 1'b0;
    #1;
    checkOutput("reset_ack", ext_ack, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_valid", rd_valid, 0);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_rd_data", rd_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("[TB] single handshake 0xA5");
    for (int i = 0; i <= REQ_LAT; i++) begin
      applyStimulus(1'b1, 8'hA5, 1'b0);
      checkOutput("ack_rise_timing", ext_ack, (i == REQ_LAT));
    end
    checkOutput("a5_rd_data", rd_data, 8'hA5);
    checkOutput("a5_count", count, 1);
    for (int i = 0; i <= REQ_LAT; i++) begin
      applyStimulus(1'b0, 8'hA5, 1'b0);
      checkOutput("ack_fall_timing", ext_ack, (i < REQ_LAT));
    end
    popByte(8'hA5);

    $display("[TB] fill to full and stall");
    for (int b = 1; b <= 4; b++) sendByte(WIDTH'(b));
    checkOutput("full_flag", full, 1);
    checkOutput("full_count", count, 4);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'h05, 1'b0);
      checkOutput("stall_ack_low", ext_ack, 0);
    end
    applyStimulus(1'b1, 8'h05, 1'b1);
    checkOutput("pop_edge_ack_low", ext_ack, 0);
    applyStimulus(1'b1, 8'h05, 1'b0);
    checkOutput("stalled_write_ack", ext_ack, 1);
    for (int i = 0; i < 20 && ext_ack; i++) applyStimulus(1'b0, 8'h05, 1'b0);
    popByte(8'h02);
    popByte(8'h03);
    popByte(8'h04);
    popByte(8'h05);

    $display("[TB] pop while empty");
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("empty_pop_count", count, 0);
    checkOutput("empty_pop_rd_data", rd_data, 0);

    $display("[TB] simultaneous write and pop");
    sendByte(8'h0F);
    sendByte(8'h20);
    for (int i = 0; i < REQ_LAT; i++) applyStimulus(1'b1, 8'h10, 1'b0);
    applyStimulus(1'b1, 8'h10, 1'b1);
    checkOutput("wr_pop_ack", ext_ack, 1);
    checkOutput("wr_pop_count", count, 2);
    checkOutput("wr_pop_head", rd_data, 8'h20);
    for (int i = 0; i < 20 && ext_ack; i++) applyStimulus(1'b0, 8'h10, 1'b0);
    popByte(8'h20);
    popByte(8'h10);

    $display("[TB] reset mid-handshake");
    sendByte(8'h31);
    sendByte(8'h32);
    for (int i = 0; i < 20 && !ext_ack; i++) applyStimulus(1'b1, 8'h33, 1'b0);
    checkOutput("pre_reset_count", count, 3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_ack", ext_ack, 0);
    checkOutput("mid_reset_count", count, 0);
    checkOutput("mid_reset_valid", rd_valid, 0);
    checkOutput("mid_reset_rd_data", rd_data, 0);
    model.delete();
    ack_prev = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20 && !ext_ack; i++) applyStimulus(1'b1, 8'h33, 1'b0);
    checkOutput("post_reset_ack", ext_ack, 1);
    checkOutput("post_reset_count", count, 1);
    checkOutput("post_reset_head", rd_data, 8'h33);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 20 && ext_ack; i++) applyStimulus(1'b0, 8'h33, 1'b0);
    checkOutput("single_write_count", count, 1);
    popByte(8'h33);

    $display("[TB] back-to-back stream");
    streamBytes(8, 1'b0, 400, cycles);
    checkOutput("b2b_period", (cycles <= 8 * PERIOD), 1);

    $display("[TB] random stream with random pops");
    streamBytes(24, 1'b1, 3000, cycles);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
